rr_arbiter4: RTL and testbench



---
 rtl/rr_arbiter4_if.sv | 32 +++
 rtl/rr_arbiter4.sv | 147 ++++++++++++++
 tb/tb_rr_arbiter4.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter4_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter4_if
// Description : Request/grant bundle between four requesters and the
//               round-robin arbiter. The master side drives requests, the
//               slave side (the arbiter) returns the registered grant view.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_arbiter4_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] gnt_id;
    logic       busy;
    logic       expired;

    modport master (
        output req,
        input  grant,
        input  gnt_id,
        input  busy,
        input  expired
    );

    modport slave (
        input  req,
        output grant,
        output gnt_id,
        output busy,
        output expired
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter4
// Description : Four-requester round-robin arbiter with a one-hot rotating
//               priority pointer, registered one-hot grant and a bounded
//               hold time per owner (forced preemption after MAX_HOLD cycles
//               while another requester waits).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8     // 1..15, fits the 4-bit hold counter
) (
    input  logic         clk,
    input  logic         reset,
    rr_arbiter4_if.slave bus
);

    localparam logic [3:0] c_MAX_HOLD = MAX_HOLD[3:0];

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [3:0] r_ptr;
    logic [3:0] r_grant;
    logic [1:0] r_gnt_id;
    logic [3:0] r_hold_cnt;
    logic       r_busy;
    logic       r_expired;

    // Returns {found, index} of the first set bit of r scanning upward from
    // start with wrap. Scanning the order backwards lets the earliest
    // candidate overwrite later ones.
    function automatic logic [2:0] f_search(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + k[1:0];
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    logic [1:0] w_ptr_idx;
    logic [1:0] w_next_ptr_idx;
    logic [3:0] w_next_ptr;
    logic [3:0] w_others;
    logic       w_owner_req;
    logic       w_at_limit;
    logic [2:0] w_idle_pick;
    logic [2:0] w_hand_pick;
    logic       w_idle_found;
    logic [1:0] w_idle_idx;
    logic       w_hand_found;
    logic [1:0] w_hand_idx;

    // Decode the one-hot pointer back into the index the search starts from.
    always_comb begin
        w_ptr_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r_ptr[i]) begin
                w_ptr_idx = i[1:0];
            end
        end
    end

    // On release or preemption the pointer advances past the owner and the
    // owner itself is excluded from the handoff search.
    assign w_next_ptr_idx = r_gnt_id + 2'd1;
    assign w_next_ptr     = 4'b0001 << w_next_ptr_idx;
    assign w_others       = bus.req & ~r_grant;
    assign w_owner_req    = |(bus.req & r_grant);
    assign w_at_limit     = (r_hold_cnt == c_MAX_HOLD);

    assign w_idle_pick  = f_search(bus.req, w_ptr_idx);
    assign w_hand_pick  = f_search(w_others, w_next_ptr_idx);
    assign w_idle_found = w_idle_pick[2];
    assign w_idle_idx   = w_idle_pick[1:0];
    assign w_hand_found = w_hand_pick[2];
    assign w_hand_idx   = w_hand_pick[1:0];

    // Arbitration state machine; every output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= 4'b0001;
            r_grant    <= 4'b0000;
            r_gnt_id   <= 2'd0;
            r_hold_cnt <= 4'd0;
            r_busy     <= 1'b0;
            r_expired  <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_idle_found) begin
                    r_grant    <= 4'b0001 << w_idle_idx;
                    r_gnt_id   <= w_idle_idx;
                    r_hold_cnt <= 4'd1;
                    r_busy     <= 1'b1;
                    r_state    <= S_GRANT;
                end
            end else begin
                if (!w_owner_req) begin
                    // Owner released: hand off without an idle gap if possible.
                    r_ptr <= w_next_ptr;
                    if (w_hand_found) begin
                        r_grant    <= 4'b0001 << w_hand_idx;
                        r_gnt_id   <= w_hand_idx;
                        r_hold_cnt <= 4'd1;
                    end else begin
                        r_grant    <= 4'b0000;
                        r_gnt_id   <= 2'd0;
                        r_hold_cnt <= 4'd0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end else if (w_at_limit) begin
                    if (w_hand_found) begin
                        // Hold limit reached with someone waiting: preempt.
                        r_ptr      <= w_next_ptr;
                        r_grant    <= 4'b0001 << w_hand_idx;
                        r_gnt_id   <= w_hand_idx;
                        r_hold_cnt <= 4'd1;
                        r_expired  <= 1'b1;
                    end else begin
                        // Nobody waiting: keep the owner, restart its window.
                        r_hold_cnt <= 4'd1;
                    end
                end else begin
                    r_hold_cnt <= r_hold_cnt + 4'd1;
                end
            end
        end
    end

    assign bus.grant   = r_grant;
    assign bus.gnt_id  = r_gnt_id;
    assign bus.busy    = r_busy;
    assign bus.expired = r_expired;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter4
// Description : Self-checking bench for rr_arbiter4 (MAX_HOLD=4). Expected
//               grant/gnt_id/busy/expired values are queued when stimulus
//               is applied and popped after the following clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter4;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       b;
        logic       e;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_mis;
    exp_t exp_q[$];

    rr_arbiter4_if ifc();

    rr_arbiter4 #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] g, input logic [1:0] id, input logic ex);
        exp_t r;
        r.g  = g;
        r.id = id;
        r.b  = |g;
        r.e  = ex;
        return r;
    endfunction

    function automatic exp_t observed();
        return {ifc.grant, ifc.gnt_id, ifc.busy, ifc.expired};
    endfunction

    task automatic do_reset();
        reset   = 1'b1;
        ifc.req = 4'b0000;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        exp_t got, e;
        reset   = 1'b1;
        ifc.req = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) reset = 1'b0;
            exp_q.push_back(c < 2 ? mk(4'b0000, 2'd0, 1'b0) : mk(4'b0001, 2'd0, 1'b0));
            @(posedge clk); #1;
            got = observed();
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL reset c=%0d scoreboard empty", c);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_mis++;
                    $display("FAIL reset c=%0d got=%b required=%b", c, got, e);
                end
            end
        end
    endtask

    task automatic test_single();
        exp_t got, e;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            ifc.req = (c < 3) ? 4'b0100 : 4'b0000;
            exp_q.push_back((c < 3) ? mk(4'b0100, 2'd2, 1'b0) : mk(4'b0000, 2'd0, 1'b0));
            @(posedge clk); #1;
            got = observed();
            n_cmp++;
            e = exp_q.pop_front();
            if (got !== e) begin
                n_mis++;
                $display("FAIL single c=%0d got=%b required=%b", c, got, e);
            end
        end
    endtask

    task automatic test_full_load();
        exp_t got, e;
        int   o;
        do_reset();
        ifc.req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            o = (c / 4) % 4;
            exp_q.push_back(mk(4'b0001 << o, o[1:0], (c % 4 == 0) && (c >= 4)));
            @(posedge clk); #1;
            got = observed();
            n_cmp++;
            e = exp_q.pop_front();
            if (got !== e) begin
                n_mis++;
                $display("FAIL full_load c=%0d got=%b required=%b", c, got, e);
            end
        end
    endtask

    task automatic test_skip();
        exp_t got, e;
        logic [1:0] o;
        do_reset();
        ifc.req = 4'b1001;
        for (int c = 0; c < 12; c++) begin
            o = ((c / 4) % 2 == 1) ? 2'd3 : 2'd0;
            exp_q.push_back(mk(4'b0001 << o, o, (c == 4) || (c == 8)));
            @(posedge clk); #1;
            got = observed();
            n_cmp++;
            e = exp_q.pop_front();
            if (got !== e) begin
                n_mis++;
                $display("FAIL skip c=%0d got=%b required=%b", c, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t got, e;
        logic [3:0] stim [5] = '{4'b1011, 4'b1011, 4'b1010, 4'b1010, 4'b0000};
        exp_t       want [5];
        want[0] = mk(4'b0001, 2'd0, 1'b0);
        want[1] = mk(4'b0001, 2'd0, 1'b0);
        want[2] = mk(4'b0010, 2'd1, 1'b0);
        want[3] = mk(4'b0010, 2'd1, 1'b0);
        want[4] = mk(4'b0000, 2'd0, 1'b0);
        do_reset();
        for (int c = 0; c < 5; c++) begin
            ifc.req = stim[c];
            exp_q.push_back(want[c]);
            @(posedge clk); #1;
            got = observed();
            n_cmp++;
            e = exp_q.pop_front();
            if (got !== e) begin
                n_mis++;
                $display("FAIL back_to_back c=%0d got=%b required=%b", c, got, e);
            end
        end
    endtask

    task automatic test_persistent();
        exp_t got, e;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            ifc.req = (c < 12) ? 4'b0001 : 4'b0000;
            exp_q.push_back((c < 12) ? mk(4'b0001, 2'd0, 1'b0) : mk(4'b0000, 2'd0, 1'b0));
            @(posedge clk); #1;
            got = observed();
            n_cmp++;
            e = exp_q.pop_front();
            if (got !== e) begin
                n_mis++;
                $display("FAIL persistent c=%0d got=%b required=%b", c, got, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t got, e;
        logic [3:0] stim [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b1001};
        logic       rst_s [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_t       want [4];
        want[0] = mk(4'b0100, 2'd2, 1'b0);
        want[1] = mk(4'b0100, 2'd2, 1'b0);
        want[2] = mk(4'b0000, 2'd0, 1'b0);
        want[3] = mk(4'b0001, 2'd0, 1'b0);
        do_reset();
        for (int c = 0; c < 4; c++) begin
            ifc.req = stim[c];
            reset   = rst_s[c];
            exp_q.push_back(want[c]);
            @(posedge clk); #1;
            got = observed();
            n_cmp++;
            e = exp_q.pop_front();
            if (got !== e) begin
                n_mis++;
                $display("FAIL reset_mid c=%0d got=%b required=%b", c, got, e);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_mis   = 0;
        reset   = 1'b1;
        ifc.req = 4'b0000;
        test_reset();
        test_single();
        test_full_load();
        test_skip();
        test_back_to_back();
        test_persistent();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
